cache_control: RTL and testbench
================================

# cache_control

Sequencing controller for the 2-way set-associative, write-back L1 cache built from two 256-bit-line data array instances (16 sets, byte-granular write enables). It holds the tag/valid/dirty/LRU metadata in registers, performs hit/miss determination, drives the data arrays' index, write-enables and input-mux selects, and runs writeback/allocate transactions on the line-wide physical memory port. It sits between the CPU-side cache interface and the arbiter/physical memory.

## Interface
- s_index, 4, set index width; sets = 2**s_index; must match data array num_index
- s_offset, 5, byte offset width within a 32-byte line (fixed)
- s_tag, 32-s_index-s_offset, tag width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  32  CPU byte address, stable while request held
- mem_byte_enable  in  4  byte lanes of the 32-bit CPU word for writes
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_address  out  32  line-aligned memory address (low 5 bits zero)
- pmem_resp  in  1  one-cycle completion from memory
- data_index  out  s_index  rindex and windex for both data arrays
- way0_write_en  out  32  byte write-enables, way 0 array
- way1_write_en  out  32  byte write-enables, way 1 array
- datain_sel  out  1  0: CPU word replicated across line; 1: pmem line
- dataout_way  out  1  way whose dataout feeds CPU read mux and pmem write data

## Operation
- Address split: tag = mem_address[31:9], index = mem_address[8:5], word = mem_address[4:2] (default params).
- data_index = index in every state.
- Metadata per set: tag[2], valid[2], dirty[2], lru (1 bit, names least-recently-used way).
- States: IDLE, CHECK, WRITEBACK, ALLOCATE.
- IDLE: all request/enable outputs 0. mem_read|mem_write high -> CHECK.
- CHECK: hit_w = valid[w] & tag[w]==tag; way 0 wins if both hit.
  - Request dropped (both low) -> IDLE, no mem_resp, no metadata change.
  - Hit: mem_resp=1, dataout_way=hit way, lru<=~hit way. If mem_write: wayN_write_en = mem_byte_enable << (4*word) on hit way only, datain_sel=0, dirty[hit]<=1. -> IDLE. mem_write has priority if both read and write high.
  - Miss: victim=lru. valid[victim]&dirty[victim] -> WRITEBACK, else ALLOCATE. No write-enables.
- WRITEBACK: pmem_write=1, pmem_address={tag[victim],index,5'b0}, dataout_way=victim. On pmem_resp: dirty[victim]<=0 -> ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_address={tag,index,5'b0}, datain_sel=1. On pmem_resp: wayvictim_write_en=32'hFFFFFFFF that cycle, tag[victim]<=tag, valid[victim]<=1, dirty[victim]<=0 -> CHECK (replay hits).
- Victim way registered on leaving CHECK; fixed through WRITEBACK/ALLOCATE.
- Request drop during WRITEBACK/ALLOCATE: transaction completes regardless; subsequent CHECK returns to IDLE without mem_resp.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE; all valid, dirty, lru, tags 0; mem_resp, pmem_read, pmem_write, write-enables, datain_sel, dataout_way, pmem_address all 0 immediately.
- Reset mid-transaction: pmem_read/pmem_write fall without waiting for pmem_resp; no partial metadata update.
- Hit latency: request first seen in IDLE at cycle 0, mem_resp in cycle 1.
- Clean miss: ALLOCATE from cycle 2; pmem_resp at cycle k; mem_resp at cycle k+1.
- Dirty miss: WRITEBACK from cycle 2; pmem_resp at j; ALLOCATE at j+1; fill pmem_resp at k; mem_resp at k+1.
- pmem_read/pmem_write held continuously until pmem_resp; never both high.
- mem_resp never asserted two consecutive cycles.
- Data array write bypass means CHECK hit data after fill is the fetched line.

## Test plan
- Reset, read 0x0000_0040 -> CHECK miss, clean ALLOCATE pmem_address 0x0000_0040, mem_resp one cycle after pmem_resp; repeat read -> mem_resp at cycle 1, no pmem activity.
- Write 0x0000_0044 be=4'b0011 after fill -> way0_write_en=32'h0000_0030, datain_sel=0, dirty set.
- Fill both ways of set 2 (0x0000_0040, 0x0000_0240), read 0x0000_0040, then miss 0x0000_0440 -> victim way1, clean ALLOCATE, way1_write_en=32'hFFFFFFFF.
- Dirty victim: write 0x0000_0040, force eviction -> WRITEBACK pmem_address 0x0000_0040, dataout_way=victim, then ALLOCATE of new line, single mem_resp.
- Assert rst_n low during ALLOCATE -> pmem_read drops same cycle, prior line now misses.
- Drop mem_read during ALLOCATE -> fill completes, line valid, no mem_resp.

Source files
------------

// File: rtl/cache_control_if.sv
// CPU, physical-memory and data-array signal bundle for cache_control.
// master is the environment side, slave is the controller side.
interface cache_control_if #(
  parameter int s_index  = 4,
  parameter int s_offset = 5
);
  logic                mem_read;
  logic                mem_write;
  logic [31:0]         mem_address;
  logic [3:0]          mem_byte_enable;
  logic                mem_resp;
  logic                pmem_read;
  logic                pmem_write;
  logic [31:0]         pmem_address;
  logic                pmem_resp;
  logic [s_index-1:0]  data_index;
  logic [31:0]         way0_write_en;
  logic [31:0]         way1_write_en;
  logic                datain_sel;
  logic                dataout_way;

  modport master (
    output mem_read, mem_write, mem_address,
    output mem_byte_enable, pmem_resp,
    input  mem_resp, pmem_read, pmem_write,
    input  pmem_address, data_index,
    input  way0_write_en, way1_write_en,
    input  datain_sel, dataout_way
  );

  modport slave (
    input  mem_read, mem_write, mem_address,
    input  mem_byte_enable, pmem_resp,
    output mem_resp, pmem_read, pmem_write,
    output pmem_address, data_index,
    output way0_write_en, way1_write_en,
    output datain_sel, dataout_way
  );
endinterface

// File: rtl/cache_control.sv
// 2-way write-back L1 cache sequencer: metadata, hit/miss,
// data-array control and writeback/allocate on the line port.
module cache_control #(
  parameter int s_index  = 4,
  parameter int s_offset = 5
) (
  input  logic clk,
  input  logic rst_n,
  cache_control_if.slave bus
);

  localparam int s_tag = 32 - s_index - s_offset;
  localparam int sets  = 1 << s_index;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [s_tag-1:0] r_tag [2][sets];
  logic [sets-1:0]  r_valid [2];
  logic [sets-1:0]  r_dirty [2];
  logic [sets-1:0]  r_lru;
  logic             r_victim;

  logic [s_tag-1:0]    w_tag;
  logic [s_index-1:0]  w_index;
  logic [s_offset-3:0] w_word;
  logic                w_req;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_hit;
  logic                w_hit_way;
  logic                w_lru;
  logic                w_vic_dirty;
  logic [31:0]         w_be_line;
  logic                w_unused_addr;

  assign w_tag   = bus.mem_address[31 -: s_tag];
  assign w_index = bus.mem_address[s_offset +: s_index];
  assign w_word  = bus.mem_address[s_offset-1:2];
  assign w_req   = bus.mem_read | bus.mem_write;
  assign w_unused_addr = &{1'b0, bus.mem_address[1:0]};

  assign w_hit0 = r_valid[0][w_index] &&
                  (r_tag[0][w_index] == w_tag);
  assign w_hit1 = r_valid[1][w_index] &&
                  (r_tag[1][w_index] == w_tag);
  assign w_hit     = w_hit0 | w_hit1;
  // way 0 wins when both ways report a hit
  assign w_hit_way = ~w_hit0;

  assign w_lru       = r_lru[w_index];
  assign w_vic_dirty = r_valid[w_lru][w_index] &
                       r_dirty[w_lru][w_index];

  assign w_be_line = 32'(bus.mem_byte_enable)
                     << {w_word, 2'b00};

  assign bus.data_index = w_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_victim <= 1'b0;
    end else if (r_state == CHECK && w_req && !w_hit) begin
      r_victim <= w_lru;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < 2; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
        for (int s = 0; s < sets; s++) begin
          r_tag[w][s] <= '0;
        end
      end
      r_lru <= '0;
    end else begin
      unique case (r_state)
        CHECK: begin
          if (w_req && w_hit) begin
            r_lru[w_index] <= ~w_hit_way;
            if (bus.mem_write) begin
              r_dirty[w_hit_way][w_index] <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            r_dirty[r_victim][w_index] <= 1'b0;
          end
        end
        ALLOCATE: begin
          if (bus.pmem_resp) begin
            r_tag[r_victim][w_index]   <= w_tag;
            r_valid[r_victim][w_index] <= 1'b1;
            r_dirty[r_victim][w_index] <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next            = r_state;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_address  = '0;
    bus.way0_write_en = '0;
    bus.way1_write_en = '0;
    bus.datain_sel    = 1'b0;
    bus.dataout_way   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) w_next = CHECK;
      end
      CHECK: begin
        if (!w_req) begin
          w_next = IDLE;
        end else if (w_hit) begin
          bus.mem_resp    = 1'b1;
          bus.dataout_way = w_hit_way;
          if (bus.mem_write) begin
            if (w_hit_way) bus.way1_write_en = w_be_line;
            else           bus.way0_write_en = w_be_line;
          end
          w_next = IDLE;
        end else if (w_vic_dirty) begin
          w_next = WRITEBACK;
        end else begin
          w_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.dataout_way  = r_victim;
        bus.pmem_address = {r_tag[r_victim][w_index],
                            w_index,
                            {s_offset{1'b0}}};
        if (bus.pmem_resp) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read    = 1'b1;
        bus.datain_sel   = 1'b1;
        bus.pmem_address = {w_tag, w_index,
                            {s_offset{1'b0}}};
        if (bus.pmem_resp) begin
          if (r_victim) bus.way1_write_en = '1;
          else          bus.way0_write_en = '1;
          w_next = CHECK;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: hits, clean/dirty misses,
// request drops and reset in the middle of a fill.
module tb_cache_control;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cache_control_if #(.s_index(4), .s_offset(5)) bus ();

  cache_control #(.s_index(4), .s_offset(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic start(input logic rd, input logic wr,
                       input logic [31:0] addr,
                       input logic [3:0] be);
    @(negedge clk);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_byte_enable = be;
    #1;
    chk("idle_resp", {31'b0, bus.mem_resp}, 0);
  endtask

  task automatic release_req();
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic hit_txn(input logic rd, input logic wr,
                         input logic [31:0] addr,
                         input logic [3:0] be,
                         input logic way,
                         input logic [31:0] we0,
                         input logic [31:0] we1);
    start(rd, wr, addr, be);
    @(negedge clk);
    #1;
    chk("hit_resp", {31'b0, bus.mem_resp}, 1);
    chk("hit_way", {31'b0, bus.dataout_way}, {31'b0, way});
    chk("hit_we0", bus.way0_write_en, we0);
    chk("hit_we1", bus.way1_write_en, we1);
    chk("hit_sel", {31'b0, bus.datain_sel}, 0);
    chk("hit_pmem",
        {30'b0, bus.pmem_read, bus.pmem_write}, 0);
    chk("hit_index", {28'b0, bus.data_index},
        {28'b0, addr[8:5]});
    release_req();
    @(negedge clk);
    #1;
    chk("hit_single", {31'b0, bus.mem_resp}, 0);
  endtask

  task automatic miss_txn(input logic rd, input logic wr,
                          input logic [31:0] addr,
                          input logic [3:0] be,
                          input bit wb,
                          input logic [31:0] wb_addr,
                          input logic vic,
                          input bit drop,
                          input logic [31:0] we0,
                          input logic [31:0] we1);
    start(rd, wr, addr, be);
    @(negedge clk);
    #1;
    chk("miss_resp", {31'b0, bus.mem_resp}, 0);
    chk("miss_we",
        bus.way0_write_en | bus.way1_write_en, 0);
    @(negedge clk);
    #1;
    if (wb) begin
      chk("wb_write", {31'b0, bus.pmem_write}, 1);
      chk("wb_read", {31'b0, bus.pmem_read}, 0);
      chk("wb_addr", bus.pmem_address, wb_addr);
      chk("wb_way", {31'b0, bus.dataout_way},
          {31'b0, vic});
      @(negedge clk);
      #1;
      chk("wb_hold", {31'b0, bus.pmem_write}, 1);
      bus.pmem_resp = 1'b1;
      #1;
      chk("wb_we",
          bus.way0_write_en | bus.way1_write_en, 0);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1;
    end
    chk("al_read", {31'b0, bus.pmem_read}, 1);
    chk("al_write", {31'b0, bus.pmem_write}, 0);
    chk("al_addr", bus.pmem_address,
        {addr[31:5], 5'b0});
    chk("al_sel", {31'b0, bus.datain_sel}, 1);
    if (drop) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chk("al_hold", {31'b0, bus.pmem_read}, 1);
    chk("al_we0", bus.way0_write_en,
        vic ? 32'h0 : 32'hFFFF_FFFF);
    chk("al_we1", bus.way1_write_en,
        vic ? 32'hFFFF_FFFF : 32'h0);
    chk("al_resp", {31'b0, bus.mem_resp}, 0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    chk("rp_pmem",
        {30'b0, bus.pmem_read, bus.pmem_write}, 0);
    if (drop) begin
      chk("drop_resp", {31'b0, bus.mem_resp}, 0);
    end else begin
      chk("rp_resp", {31'b0, bus.mem_resp}, 1);
      chk("rp_way", {31'b0, bus.dataout_way},
          {31'b0, vic});
      chk("rp_we0", bus.way0_write_en, we0);
      chk("rp_we1", bus.way1_write_en, we1);
      release_req();
    end
    @(negedge clk);
    #1;
    chk("rp_single", {31'b0, bus.mem_resp}, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_byte_enable = '0;
    bus.pmem_resp       = 1'b0;
    #1;
    chk("rst_resp", {31'b0, bus.mem_resp}, 0);
    chk("rst_pmem",
        {30'b0, bus.pmem_read, bus.pmem_write}, 0);
    chk("rst_paddr", bus.pmem_address, 0);
    chk("rst_we",
        bus.way0_write_en | bus.way1_write_en, 0);
    chk("rst_sel",
        {30'b0, bus.datain_sel, bus.dataout_way}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // clean fill of set 2 into way 0, then hit
    miss_txn(1, 0, 32'h40, 4'h0, 0, 0, 0, 0, 0, 0);
    hit_txn(1, 0, 32'h40, 4'h0, 0, 0, 0);
    hit_txn(0, 1, 32'h44, 4'b0011, 0, 32'h30, 0);

    // second way of set 2, then LRU-selected clean victim
    miss_txn(1, 0, 32'h240, 4'h0, 0, 0, 1, 0, 0, 0);
    hit_txn(1, 0, 32'h40, 4'h0, 0, 0, 0);
    miss_txn(1, 0, 32'h440, 4'h0, 0, 0, 1, 0, 0, 0);

    // dirty way 0 evicted: writeback then fill
    miss_txn(1, 0, 32'h640, 4'h0, 1, 32'h40, 0, 0, 0, 0);
    hit_txn(1, 0, 32'h440, 4'h0, 1, 0, 0);

    // reset while a fill is outstanding
    start(1, 0, 32'hA0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_read", {31'b0, bus.pmem_read}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read", {31'b0, bus.pmem_read}, 0);
    chk("mid_rst_write", {31'b0, bus.pmem_write}, 0);
    chk("mid_rst_addr", bus.pmem_address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_read = 1'b0;
    miss_txn(1, 0, 32'h640, 4'h0, 0, 0, 0, 0, 0, 0);

    // request withdrawn in CHECK on a miss
    start(1, 0, 32'hC0, 4'h0);
    @(negedge clk);
    #1;
    chk("ckdrop_resp", {31'b0, bus.mem_resp}, 0);
    bus.mem_read = 1'b0;
    @(negedge clk);
    #1;
    chk("ckdrop_pmem1",
        {30'b0, bus.pmem_read, bus.pmem_write}, 0);
    @(negedge clk);
    #1;
    chk("ckdrop_pmem2",
        {30'b0, bus.pmem_read, bus.pmem_write}, 0);

    // request withdrawn during ALLOCATE still fills
    miss_txn(1, 0, 32'h860, 4'h0, 0, 0, 0, 1, 0, 0);
    hit_txn(1, 0, 32'h860, 4'h0, 0, 0, 0);
    hit_txn(1, 1, 32'h864, 4'hF, 0, 32'hF0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
